// File: rtl/systolic_ctrl_if.sv
// Bundle of control, buffer-read and array-facing signals for systolic_ctrl.
// master is the controller side; slave is the buffers/array side.
interface systolic_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = $clog2(N)
);
  logic            start;
  logic [7:0]      num_vec;
  logic            busy;
  logic            done;
  logic            w_rd_en;
  logic [AW-1:0]   w_rd_addr;
  logic [N*DW-1:0] w_rd_data;
  logic            a_rd_en;
  logic [7:0]      a_rd_addr;
  logic [N*DW-1:0] a_rd_data;
  logic            sa_load_weights;
  logic [N*DW-1:0] sa_B_flat;
  logic [N*DW-1:0] sa_A_flat;
  logic [N*DW-1:0] sa_C_flat;
  logic            res_valid;
  logic [7:0]      res_addr;
  logic [N*DW-1:0] res_data;

  modport master (
    input  start, num_vec, w_rd_data, a_rd_data, sa_C_flat,
    output busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
           sa_load_weights, sa_B_flat, sa_A_flat, res_valid, res_addr, res_data
  );

  modport slave (
    output start, num_vec, w_rd_data, a_rd_data, sa_C_flat,
    input  busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
           sa_load_weights, sa_B_flat, sa_A_flat, res_valid, res_addr, res_data
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an NxN weight-stationary systolic array: loads weights
// bottom row first, streams A columns, and tags results coming back out.
module systolic_ctrl #(
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int RES_LAT = 2*N,
  parameter int AW      = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  systolic_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic [7:0]      nv;
  logic            busy_r;
  logic            done_r;
  logic            w_en_r;
  logic [AW-1:0]   w_addr_r;
  logic            a_en_r;
  logic [7:0]      a_addr_r;

  logic            w_vld_p0;
  logic            a_vld_p0;
  logic [7:0]      a_idx_p0;

  logic            trk_vld_p1 [RES_LAT];
  logic [7:0]      trk_idx_p1 [RES_LAT];

  logic            res_vld_p2;
  logic [7:0]      res_addr_p2;
  logic [N*DW-1:0] res_data_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      nv       <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      w_en_r   <= 1'b0;
      w_addr_r <= '0;
      a_en_r   <= 1'b0;
      a_addr_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            nv       <= bus.num_vec;
            busy_r   <= 1'b1;
            w_en_r   <= 1'b1;
            w_addr_r <= AW'(N-1);
            a_addr_r <= '0;
            state    <= S_WLOAD;
          end
        end
        S_WLOAD: begin
          // weights shift downward, so the bottom row must enter first
          if (w_addr_r == '0) begin
            w_en_r <= 1'b0;
            if (nv != 8'd0) begin
              a_en_r   <= 1'b1;
              a_addr_r <= '0;
              state    <= S_STREAM;
            end else begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= S_DONE;
            end
          end else begin
            w_addr_r <= w_addr_r - 1'b1;
          end
        end
        S_STREAM: begin
          if (a_addr_r == nv - 8'd1) begin
            a_en_r <= 1'b0;
            state  <= S_DRAIN;
          end else begin
            a_addr_r <= a_addr_r + 8'd1;
          end
        end
        S_DRAIN: begin
          if (res_vld_p2 && (res_addr_p2 == nv - 8'd1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // p0: buffer read data is valid this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_vld_p0 <= 1'b0;
      a_vld_p0 <= 1'b0;
      a_idx_p0 <= '0;
    end else begin
      w_vld_p0 <= w_en_r;
      a_vld_p0 <= a_en_r;
      a_idx_p0 <= a_addr_r;
    end
  end

  // p1: column tags travel alongside the array's compute latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RES_LAT; i++) begin
        trk_vld_p1[i] <= 1'b0;
        trk_idx_p1[i] <= '0;
      end
    end else begin
      trk_vld_p1[0] <= a_vld_p0;
      trk_idx_p1[0] <= a_idx_p0;
      for (int i = 1; i < RES_LAT; i++) begin
        trk_vld_p1[i] <= trk_vld_p1[i-1];
        trk_idx_p1[i] <= trk_idx_p1[i-1];
      end
    end
  end

  // p2: capture the array result row together with its column tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_p2  <= 1'b0;
      res_addr_p2 <= '0;
      res_data_p2 <= '0;
    end else begin
      res_vld_p2 <= trk_vld_p1[RES_LAT-1];
      if (trk_vld_p1[RES_LAT-1]) begin
        res_addr_p2 <= trk_idx_p1[RES_LAT-1];
        res_data_p2 <= bus.sa_C_flat;
      end
    end
  end

  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.w_rd_en         = w_en_r;
  assign bus.w_rd_addr       = w_addr_r;
  assign bus.a_rd_en         = a_en_r;
  assign bus.a_rd_addr       = a_addr_r;
  assign bus.sa_load_weights = w_vld_p0;
  assign bus.sa_B_flat       = w_vld_p0 ? bus.w_rd_data : '0;
  assign bus.sa_A_flat       = a_vld_p0 ? bus.a_rd_data : '0;
  assign bus.res_valid       = res_vld_p2;
  assign bus.res_addr        = res_addr_p2;
  assign bus.res_data        = res_data_p2;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with N=4, RES_LAT=8, using simple
// registered buffer models and a pure-delay array model.
module tb_systolic_ctrl;
  localparam int N       = 4;
  localparam int DW      = 16;
  localparam int RES_LAT = 8;
  localparam int AW      = 2;
  localparam logic [N*DW-1:0] C_MASK = {N{16'h5a5a}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .DW(DW), .AW(AW)) bus ();

  systolic_ctrl #(.N(N), .DW(DW), .RES_LAT(RES_LAT), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [N*DW-1:0] w_row(input int r);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'(32'h1000 + r*16 + i);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] a_col(input int j);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'(32'ha000 + j*N + i);
    return v;
  endfunction

  // Buffers return data one cycle after the strobe; garbage when not strobed.
  always_ff @(posedge clk) begin
    bus.w_rd_data <= bus.w_rd_en ? w_row(int'(bus.w_rd_addr)) : '1;
    bus.a_rd_data <= bus.a_rd_en ? a_col(int'(bus.a_rd_addr)) : '1;
  end

  // Array model: result row is the A column RES_LAT cycles later, masked.
  logic [N*DW-1:0] dl [RES_LAT];
  always_ff @(posedge clk) begin
    dl[0] <= bus.sa_A_flat;
    for (int i = 1; i < RES_LAT; i++) dl[i] <= dl[i-1];
  end
  assign bus.sa_C_flat = dl[RES_LAT-1] ^ C_MASK;

  task automatic launch(input logic [7:0] nv);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_vec = nv;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.num_vec = 8'haa;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.sa_load_weights, bus.res_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=000000",
        {bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.sa_load_weights, bus.res_valid});
    end
    total++;
    if ({bus.w_rd_addr, bus.a_rd_addr, bus.res_addr} !== '0) begin
      bad++; $display("FAIL reset_addrs got=%h exp=0", {bus.w_rd_addr, bus.a_rd_addr, bus.res_addr});
    end
    total++;
    if ({bus.sa_A_flat, bus.sa_B_flat, bus.res_data} !== '0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {bus.sa_A_flat, bus.sa_B_flat, bus.res_data});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.sa_load_weights, bus.res_valid} !== 6'b0) begin
        bad++; $display("FAIL idle_strobes k=%0d got=%b exp=000000", k,
          {bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.sa_load_weights, bus.res_valid});
      end
    end
  endtask

  task automatic test_basic();
    logic [N*DW-1:0] eb, ea, er;
    logic [5:0] es, gs;
    logic ew, el, ean, erv, ed, ebz;
    launch(8'd3);
    for (int k = 0; k <= 20; k++) begin
      ew  = (k <= 3);
      el  = (k >= 1 && k <= 4);
      ean = (k >= 4 && k <= 6);
      erv = (k >= 14 && k <= 16);
      ed  = (k == 17);
      ebz = (k <= 16);
      es  = {ew, el, ean, erv, ed, ebz};
      gs  = {bus.w_rd_en, bus.sa_load_weights, bus.a_rd_en, bus.res_valid, bus.done, bus.busy};
      eb  = el ? w_row(4 - k) : '0;
      ea  = (k >= 5 && k <= 7) ? a_col(k - 5) : '0;
      er  = a_col(k - 14) ^ C_MASK;
      total++;
      if (gs !== es) begin
        bad++; $display("FAIL basic_strobes k=%0d got=%b exp=%b", k, gs, es);
      end
      total++;
      if (bus.sa_B_flat !== eb) begin
        bad++; $display("FAIL basic_sa_B k=%0d got=%h exp=%h", k, bus.sa_B_flat, eb);
      end
      total++;
      if (bus.sa_A_flat !== ea) begin
        bad++; $display("FAIL basic_sa_A k=%0d got=%h exp=%h", k, bus.sa_A_flat, ea);
      end
      if (ew) begin
        total++;
        if (bus.w_rd_addr !== AW'(3 - k)) begin
          bad++; $display("FAIL basic_w_rd_addr k=%0d got=%0d exp=%0d", k, bus.w_rd_addr, 3 - k);
        end
      end
      if (ean) begin
        total++;
        if (bus.a_rd_addr !== 8'(k - 4)) begin
          bad++; $display("FAIL basic_a_rd_addr k=%0d got=%0d exp=%0d", k, bus.a_rd_addr, k - 4);
        end
      end
      if (erv) begin
        total++;
        if (bus.res_addr !== 8'(k - 14)) begin
          bad++; $display("FAIL basic_res_addr k=%0d got=%0d exp=%0d", k, bus.res_addr, k - 14);
        end
        total++;
        if (bus.res_data !== er) begin
          bad++; $display("FAIL basic_res_data k=%0d got=%h exp=%h", k, bus.res_data, er);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero();
    int wc = 0;
    int lc = 0;
    int dk = -1;
    launch(8'd0);
    for (int k = 0; k <= 10; k++) begin
      if (bus.w_rd_en) wc++;
      if (bus.sa_load_weights) lc++;
      if (bus.done) dk = (dk < 0) ? k : 100;
      total++;
      if ({bus.a_rd_en, bus.res_valid} !== 2'b00) begin
        bad++; $display("FAIL zero_no_stream k=%0d got=%b exp=00", k, {bus.a_rd_en, bus.res_valid});
      end
      total++;
      if (bus.busy !== (k < 4)) begin
        bad++; $display("FAIL zero_busy k=%0d got=%b exp=%b", k, bus.busy, (k < 4));
      end
      @(negedge clk);
    end
    total++;
    if (wc != 4) begin bad++; $display("FAIL zero_w_reads got=%0d exp=4", wc); end
    total++;
    if (lc != 4) begin bad++; $display("FAIL zero_loads got=%0d exp=4", lc); end
    total++;
    if (dk != 4) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=4", dk); end
  endtask

  task automatic test_long();
    logic erv;
    launch(8'd255);
    for (int k = 0; k <= 280; k++) begin
      erv = (k >= 14 && k <= 268);
      total++;
      if (bus.res_valid !== erv) begin
        bad++; $display("FAIL long_res_valid k=%0d got=%b exp=%b", k, bus.res_valid, erv);
      end
      if (erv) begin
        total++;
        if (bus.res_addr !== 8'(k - 14)) begin
          bad++; $display("FAIL long_res_addr k=%0d got=%0d exp=%0d", k, bus.res_addr, k - 14);
        end
      end
      total++;
      if (bus.done !== (k == 269)) begin
        bad++; $display("FAIL long_done k=%0d got=%b exp=%b", k, bus.done, (k == 269));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int ac = 0;
    int rc = 0;
    int dk = -1;
    int la = -1;
    launch(8'd3);
    for (int k = 0; k <= 22; k++) begin
      bus.start   = (k == 5);
      bus.num_vec = (k == 5) ? 8'd7 : 8'haa;
      if (bus.a_rd_en) ac++;
      if (bus.res_valid) begin rc++; la = int'(bus.res_addr); end
      if (bus.done) dk = (dk < 0) ? k : 100;
      if (k >= 18) begin
        total++;
        if (bus.busy !== 1'b0) begin
          bad++; $display("FAIL ignore_idle_busy k=%0d got=%b exp=0", k, bus.busy);
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    total++;
    if (ac != 3) begin bad++; $display("FAIL ignore_a_reads got=%0d exp=3", ac); end
    total++;
    if (rc != 3) begin bad++; $display("FAIL ignore_results got=%0d exp=3", rc); end
    total++;
    if (la != 2) begin bad++; $display("FAIL ignore_last_addr got=%0d exp=2", la); end
    total++;
    if (dk != 17) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=17", dk); end
  endtask

  task automatic test_reset_mid();
    logic erv, ed;
    launch(8'd3);
    repeat (14) @(negedge clk);
    total++;
    if ({bus.res_valid, bus.res_addr} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL midrst_pre got=%b/%0d exp=1/0", bus.res_valid, bus.res_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.sa_load_weights, bus.res_valid} !== 6'b0) begin
      bad++; $display("FAIL midrst_strobes got=%b exp=000000",
        {bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.sa_load_weights, bus.res_valid});
    end
    total++;
    if ({bus.w_rd_addr, bus.a_rd_addr, bus.res_addr, bus.sa_A_flat, bus.sa_B_flat, bus.res_data} !== '0) begin
      bad++; $display("FAIL midrst_data got=%h/%h/%h exp=0", bus.a_rd_addr, bus.res_addr, bus.res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      total++;
      if ({bus.res_valid, bus.done, bus.busy} !== 3'b000) begin
        bad++; $display("FAIL midrst_after k=%0d got=%b exp=000", k, {bus.res_valid, bus.done, bus.busy});
      end
    end
    launch(8'd2);
    for (int k = 0; k <= 18; k++) begin
      erv = (k >= 14 && k <= 15);
      ed  = (k == 16);
      total++;
      if ({bus.res_valid, bus.done} !== {erv, ed}) begin
        bad++; $display("FAIL midrst_fresh k=%0d got=%b exp=%b", k, {bus.res_valid, bus.done}, {erv, ed});
      end
      if (erv) begin
        total++;
        if (bus.res_addr !== 8'(k - 14)) begin
          bad++; $display("FAIL midrst_fresh_addr k=%0d got=%0d exp=%0d", k, bus.res_addr, k - 14);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] es, gs;
    int dk = -1;
    launch(8'd2);
    for (int k = 0; k <= 40 && dk < 0; k++) begin
      if (bus.done) dk = k;
      else @(negedge clk);
    end
    total++;
    if (dk != 16) begin bad++; $display("FAIL b2b_first_done got=%0d exp=16", dk); end
    launch(8'd2);
    for (int k = 0; k <= 18; k++) begin
      es = {(k <= 3), (k >= 4 && k <= 5), (k >= 14 && k <= 15), (k == 16)};
      gs = {bus.w_rd_en, bus.a_rd_en, bus.res_valid, bus.done};
      total++;
      if (gs !== es) begin
        bad++; $display("FAIL b2b_strobes k=%0d got=%b exp=%b", k, gs, es);
      end
      if (k == 0) begin
        total++;
        if ({bus.busy, bus.w_rd_addr} !== {1'b1, 2'd3}) begin
          bad++; $display("FAIL b2b_first_cycle got=%b/%0d exp=1/3", bus.busy, bus.w_rd_addr);
        end
      end
      if (bus.res_valid && es[1]) begin
        total++;
        if (bus.res_addr !== 8'(k - 14)) begin
          bad++; $display("FAIL b2b_res_addr k=%0d got=%0d exp=%0d", k, bus.res_addr, k - 14);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.num_vec = 8'd0;
    test_reset();
    test_basic();
    test_zero();
    test_long();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension (NxN); N >= 2.
REQ-002 Parameter DW, default 16: element data width.
REQ-003 Parameter RES_LAT, default 2*N: cycles from a column on sa_A_flat to its result on sa_C_flat; RES_LAT >= 1.
REQ-004 Parameter AW = $clog2(N): weight-row address width.
REQ-005 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  launch a job; sampled in IDLE only.
- num_vec  in  8  A columns to stream; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- w_rd_en  out  1  weight buffer read strobe.
- w_rd_addr  out  AW  weight row address.
- w_rd_data  in  N*DW  weight row; valid 1 cycle after w_rd_en.
- a_rd_en  out  1  A buffer read strobe.
- a_rd_addr  out  8  A column index.
- a_rd_data  in  N*DW  A column; valid 1 cycle after a_rd_en.
- sa_load_weights  out  1  array weight-shift enable.
- sa_B_flat  out  N*DW  weight row to array.
- sa_A_flat  out  N*DW  A column to array.
- sa_C_flat  in  N*DW  result row from array.
- res_valid  out  1  res_data/res_addr valid.
- res_addr  out  8  column index of result.
- res_data  out  N*DW  captured sa_C_flat.

Function
REQ-007 FSM states: IDLE, WLOAD, STREAM, DRAIN, DONE; encoding is implementation choice.
REQ-008 IDLE: start=1 -> latch num_vec, clear counters, go WLOAD; busy=1 from next cycle.
REQ-009 WLOAD: N cycles, cycle k (0..N-1) asserts w_rd_en with w_rd_addr = N-1-k (bottom row first, since weights shift down).
REQ-010 sa_load_weights = w_rd_en delayed 1 cycle; sa_B_flat = w_rd_data when delayed strobe high, else 0; exactly N load pulses per job.
REQ-011 After cycle k=N-1: go STREAM if latched num_vec != 0, else go DONE.
REQ-012 STREAM: num_vec cycles, cycle j asserts a_rd_en with a_rd_addr = j; last issue -> DRAIN.
REQ-013 sa_A_flat = a_rd_data in the cycle after a_rd_en, else 0; the first A column never coincides with a load pulse.
REQ-014 Result tracking: valid/index shift pipeline of depth RES_LAT; column j on sa_A_flat at cycle t -> res_valid=1, res_addr=j, res_data=sa_C_flat (registered) exactly RES_LAT+1 cycles after t.
REQ-015 DRAIN: hold until last result (res_addr = num_vec-1) emitted, then DONE.
REQ-016 DONE: done=1 one cycle, busy=0 in that cycle, return IDLE; new start accepted the next cycle.
REQ-017 start while not IDLE is ignored; num_vec changes after acceptance have no effect.
REQ-018 Results emitted in index order, exactly num_vec per job, no gaps in res_valid during back-to-back columns.
REQ-019 All strobes (w_rd_en, a_rd_en, sa_load_weights, res_valid, done) are 0 in IDLE.

Reset
REQ-020 rst_n low, any state -> immediately IDLE; busy, done, w_rd_en, a_rd_en, sa_load_weights, res_valid = 0; all addresses, sa_A_flat, sa_B_flat, res_data, and pipeline = 0.
REQ-021 Reset mid-job aborts it: no further res_valid or done for that job after release.
REQ-022 First start after rst_n release is accepted.

Verification
REQ-023 N=4, num_vec=3, RES_LAT=8: start -> w_rd_addr 3,2,1,0 on 4 consecutive cycles; 4 load pulses; a_rd_addr 0,1,2; res_valid at 9 cycles after each column, addr 0,1,2; one done.
REQ-024 num_vec=0: 4 weight reads, no a_rd_en, no res_valid; done 1 cycle after last weight issue.
REQ-025 num_vec=255: 255 consecutive res_valid, addr 0..254, no gap; done after addr 254.
REQ-026 start pulsed during STREAM with num_vec=7 -> ignored; job finishes with original count.
REQ-027 rst_n asserted in DRAIN with 2 results pending -> all outputs 0 at once; no res_valid/done after release; fresh start runs normally.
REQ-028 Back-to-back: start asserted in cycle after done -> second job starts cleanly, res_addr restarts at 0.
